// File: rtl/pkg_framer_pkg.sv
// -----------------------------------------------------------------------------
// pkg_framer_pkg
// Shared definitions for the package framer. It holds the FSM state encoding,
// the frame constants and the header byte selector.
// This file has no ports.
// -----------------------------------------------------------------------------
package pkg_framer_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_REQ,
        RD_WAIT,
        PAY,
        CSUM
    } state_t;

    localparam byte_t SYNC0       = 8'hA5;
    localparam byte_t SYNC1       = 8'h5A;
    localparam int    HDR_LEN     = 6;
    localparam int    TRAILER_LEN = 1;

    // Header layout: sync word, sequence number, payload length (both MSB first).
    function automatic byte_t hdr_byte(input logic [2:0]  idx,
                                       input logic [15:0] seq,
                                       input logic [15:0] len);
        case (idx)
            3'd0:    return SYNC0;
            3'd1:    return SYNC1;
            3'd2:    return seq[15:8];
            3'd3:    return seq[7:0];
            3'd4:    return len[15:8];
            default: return len[7:0];
        endcase
    endfunction

endpackage

// File: rtl/pkg_framer_if.sv
// -----------------------------------------------------------------------------
// pkg_framer_if
// Groups the framer's two handshakes: the ring_fifo read side and the
// valid/ready byte stream toward the WiFi transmitter.
//   package_ready : full package available in the FIFO
//   fifo_rd_en    : single-cycle read request to the FIFO
//   fifo_valid    : fifo_dout carries a byte this cycle
//   fifo_dout     : FIFO read data
//   tx_data       : frame byte
//   tx_valid      : tx_data is valid
//   tx_ready      : sink accepts the byte
// master = framer side, slave = FIFO + transmitter side.
// -----------------------------------------------------------------------------
interface pkg_framer_if;
    import pkg_framer_pkg::*;

    logic  package_ready;
    logic  fifo_rd_en;
    logic  fifo_valid;
    byte_t fifo_dout;
    byte_t tx_data;
    logic  tx_valid;
    logic  tx_ready;

    modport master (
        input  package_ready, fifo_valid, fifo_dout, tx_ready,
        output fifo_rd_en, tx_data, tx_valid
    );

    modport slave (
        output package_ready, fifo_valid, fifo_dout, tx_ready,
        input  fifo_rd_en, tx_data, tx_valid
    );

endinterface

// File: rtl/pkg_framer.sv
// -----------------------------------------------------------------------------
// pkg_framer
// Drains one complete package from ring_fifo a byte at a time. It wraps the
// payload as: A5 5A seq_hi seq_lo len_hi len_lo payload... csum.
// csum is the 8-bit sum of seq, len and payload bytes. A read that gets no
// fifo_valid within rd_timeout cycles is padded with 0x00 and flags
// err_timeout, so the frame length is always package_size + 7.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (master)       : FIFO read handshake + tx valid/ready stream
//   busy               : high whenever the FSM is not in IDLE
//   seq                : sequence number of the next frame
//   err_timeout        : sticky read-timeout flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module pkg_framer
    import pkg_framer_pkg::*;
#(
    parameter int data_width   = 8,
    parameter int package_size = 60,
    parameter int rd_timeout   = 64
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    pkg_framer_if.master        bus,
    output logic                busy,
    output logic [15:0]         seq,
    output logic                err_timeout
);

    localparam logic [15:0] LEN      = 16'(package_size);
    localparam logic [7:0]  TMO_LAST = 8'(rd_timeout - 1);
    localparam logic [2:0]  HDR_LAST = 3'(HDR_LEN - 1);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [15:0]            pay_q, pay_d;
    logic [7:0]             tmo_q, tmo_d;
    logic [data_width-1:0]  csum_q, csum_d;
    logic [data_width-1:0]  txd_q, txd_d;
    logic                   txv_q, txv_d;
    logic                   rd_q, rd_d;
    logic                   busy_q, busy_d;
    logic [15:0]            seq_q, seq_d;
    logic                   err_q, err_d;
    logic                   hs;

    assign hs = txv_q && bus.tx_ready;

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // NOTE: every *_d gets a default (hold or idle value) before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pay_d   = pay_q;
        tmo_d   = tmo_q;
        csum_d  = csum_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        rd_d    = 1'b0;
        seq_d   = seq_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.package_ready) begin
                    state_d = HDR;
                    idx_d   = 3'd0;
                    pay_d   = 16'd0;
                    txd_d   = SYNC0;
                    txv_d   = 1'b1;
                end
            end
            HDR: begin
                if (hs) begin
                    // Sync bytes are excluded from the checksum.
                    if (idx_q >= 3'd2) csum_d = csum_q + txd_q;
                    if (idx_q == HDR_LAST) begin
                        state_d = RD_REQ;
                        txv_d   = 1'b0;
                        rd_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = hdr_byte(idx_q + 3'd1, seq_q, LEN);
                    end
                end
            end
            RD_REQ: begin
                // rd_q is high for exactly this one cycle.
                state_d = RD_WAIT;
                tmo_d   = 8'd0;
            end
            RD_WAIT: begin
                if (bus.fifo_valid) begin
                    state_d = PAY;
                    txd_d   = bus.fifo_dout;
                    txv_d   = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    // Pad so the frame length stays fixed; the sink never stalls forever.
                    state_d = PAY;
                    txd_d   = '0;
                    txv_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            PAY: begin
                if (hs) begin
                    csum_d = csum_q + txd_q;
                    pay_d  = pay_q + 16'd1;
                    if (pay_q == LEN - 16'd1) begin
                        state_d = CSUM;
                        txd_d   = csum_q + txd_q;
                    end else begin
                        state_d = RD_REQ;
                        txv_d   = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end
            CSUM: begin
                if (hs) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 16'd1;
                    csum_d  = '0;
                    txv_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: every register here is reset; there is no storage array, so the
    // whole datapath returns to a known state on sys_rst_n.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q  <= '0;
            pay_q  <= '0;
            tmo_q  <= '0;
            csum_q <= '0;
            txd_q  <= '0;
            txv_q  <= 1'b0;
            rd_q   <= 1'b0;
            busy_q <= 1'b0;
            seq_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            pay_q  <= pay_d;
            tmo_q  <= tmo_d;
            csum_q <= csum_d;
            txd_q  <= txd_d;
            txv_q  <= txv_d;
            rd_q   <= rd_d;
            busy_q <= busy_d;
            seq_q  <= seq_d;
            err_q  <= err_d;
        end
    end

    assign bus.tx_data    = txd_q;
    assign bus.tx_valid   = txv_q;
    assign bus.fifo_rd_en = rd_q;
    assign busy           = busy_q;
    assign seq            = seq_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_pkg_framer.sv
// -----------------------------------------------------------------------------
// tb_pkg_framer
// Directed bench for pkg_framer with package_size=4 and rd_timeout=8. A
// 1-cycle-latency FIFO model and a byte sink are advanced one cycle at a time
// by the step task. All sampling happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pkg_framer;
    import pkg_framer_pkg::*;

    localparam int PSIZE = 4;
    localparam int TMO   = 8;
    localparam int FLEN  = HDR_LEN + PSIZE + TRAILER_LEN;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        busy;
    logic [15:0] seq;
    logic        err_timeout;

    pkg_framer_if bus ();

    pkg_framer #(
        .data_width   (8),
        .package_size (PSIZE),
        .rd_timeout   (TMO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .bus         (bus),
        .busy        (busy),
        .seq         (seq),
        .err_timeout (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int          total = 0;
    int          bad = 0;
    int          steps = 0;
    int          rd_frame_cnt = 0;
    int          drop_idx = -1;
    bit          pend = 1'b0;
    bit          prev_rd = 1'b0;
    bit          hold = 1'b0;
    bit          stray = 1'b0;
    bit          rand_ready = 1'b0;
    bit          rand_data = 1'b0;
    logic [7:0]  pend_data = 8'h00;
    logic [7:0]  held = 8'h00;
    logic [7:0]  rx_q[$];
    logic [7:0]  sent_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sink decision and capture, stall-stability check and
    // FIFO model response, all evaluated at the falling edge.
    task automatic step();
        logic [7:0] d;
        @(negedge sys_clk);
        steps++;
        if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
        if (hold) begin
            chk("hold_valid", 32'(bus.tx_valid), 32'd1);
            chk("hold_data", 32'(bus.tx_data), 32'(held));
        end
        if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
        hold = bus.tx_valid && !bus.tx_ready;
        held = bus.tx_data;

        if (prev_rd) chk("rd_en_gap", 32'(bus.fifo_rd_en), 32'd0);
        bus.fifo_valid = pend;
        bus.fifo_dout  = pend ? pend_data : 8'h00;
        pend = 1'b0;
        if (stray) begin
            bus.fifo_valid = 1'b1;
            bus.fifo_dout  = 8'hEE;
            stray = 1'b0;
        end
        if (bus.fifo_rd_en) begin
            d = rand_data ? 8'($urandom) : 8'(rd_frame_cnt + 1);
            if (rd_frame_cnt == drop_idx) begin
                sent_q.push_back(8'h00);
            end else begin
                pend      = 1'b1;
                pend_data = d;
                sent_q.push_back(d);
            end
            rd_frame_cnt++;
        end
        prev_rd = bus.fifo_rd_en;
    endtask

    task automatic collect(input int n, input int budget);
        int start;
        start = steps;
        while (rx_q.size() < n && (steps - start) < budget) step();
        if (rx_q.size() < n) chk("collect_timeout", 32'(rx_q.size()), 32'(n));
    endtask

    // Builds the expected frame from the bytes the FIFO model delivered.
    task automatic check_frame(input string tag, input logic [15:0] s);
        logic [7:0] exp_b [FLEN];
        logic [7:0] cs;
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'h5A;
        exp_b[2] = s[15:8];
        exp_b[3] = s[7:0];
        exp_b[4] = 8'(PSIZE >> 8);
        exp_b[5] = 8'(PSIZE);
        for (int i = 0; i < PSIZE; i++)
            exp_b[HDR_LEN + i] = (i < sent_q.size()) ? sent_q[i] : 8'h00;
        cs = 8'h00;
        for (int i = 2; i < FLEN - 1; i++) cs = cs + exp_b[i];
        exp_b[FLEN - 1] = cs;
        for (int i = 0; i < FLEN; i++)
            chk($sformatf("%s_b%0d", tag, i),
                (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
        repeat (FLEN) if (rx_q.size() > 0) void'(rx_q.pop_front());
        repeat (PSIZE) if (sent_q.size() > 0) void'(sent_q.pop_front());
    endtask

    initial begin
        bus.package_ready = 1'b0;
        bus.fifo_valid    = 1'b0;
        bus.fifo_dout     = 8'h00;
        bus.tx_ready      = 1'b1;

        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seq", 32'(seq), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        sys_rst_n = 1'b1;
        step();
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Basic frame: payload 01 02 03 04 -> csum 0x0E, 19 cycles to csum
        steps = 0;
        bus.package_ready = 1'b1;
        step();
        chk("t1_lat_valid", 32'(bus.tx_valid), 32'd1);
        chk("t1_lat_data", 32'(bus.tx_data), 32'hA5);
        chk("t1_busy", 32'(busy), 32'd1);
        bus.package_ready = 1'b0;
        collect(FLEN, 100);
        chk("t1_cycles", 32'(steps), 32'd19);
        chk("t1_csum", 32'(rx_q[FLEN - 1]), 32'h0E);
        check_frame("t1", 16'h0000);
        chk("t1_rd_count", 32'(rd_frame_cnt), 32'(PSIZE));
        rd_frame_cnt = 0;
        step();
        step();
        chk("t1_seq", 32'(seq), 32'd1);
        chk("t1_err", 32'(err_timeout), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Third read never answered: padded 0x00 after 8 wait cycles, csum 0x0C
        drop_idx = 2;
        steps = 0;
        bus.package_ready = 1'b1;
        step();
        bus.package_ready = 1'b0;
        collect(FLEN, 200);
        chk("to_cycles", 32'(steps), 32'd26);
        chk("to_pad", 32'(rx_q[HDR_LEN + 2]), 32'h00);
        chk("to_csum", 32'(rx_q[FLEN - 1]), 32'h0C);
        check_frame("to", 16'h0001);
        chk("to_err", 32'(err_timeout), 32'd1);
        drop_idx = -1;
        rd_frame_cnt = 0;
        step();
        step();
        chk("to_seq", 32'(seq), 32'd2);

        // Back-to-back frames with a stray fifo_valid during the header
        bus.package_ready = 1'b1;
        step();
        stray = 1'b1;
        collect(FLEN, 200);
        check_frame("b2b0", 16'h0002);
        chk("b2b0_rd_count", 32'(rd_frame_cnt), 32'(PSIZE));
        rd_frame_cnt = 0;
        step();
        chk("b2b_gap_valid", 32'(bus.tx_valid), 32'd0);
        step();
        chk("b2b_next_valid", 32'(bus.tx_valid), 32'd1);
        chk("b2b_next_data", 32'(bus.tx_data), 32'hA5);
        collect(FLEN, 200);
        check_frame("b2b1", 16'h0003);
        chk("b2b1_rd_count", 32'(rd_frame_cnt), 32'(PSIZE));
        rd_frame_cnt = 0;

        // 100 frames with random back-pressure and random payload
        rand_ready = 1'b1;
        rand_data  = 1'b1;
        for (int f = 0; f < 100; f++) begin
            collect(FLEN, 400);
            if (f == 99) bus.package_ready = 1'b0;
            check_frame("rnd", 16'(4 + f));
            chk("rnd_rd_count", 32'(rd_frame_cnt), 32'(PSIZE));
            rd_frame_cnt = 0;
        end
        rand_ready   = 1'b0;
        rand_data    = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) step();
        chk("rnd_seq", 32'(seq), 32'd104);

        // Reset during payload byte 2
        bus.package_ready = 1'b1;
        collect(HDR_LEN + 2, 100);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("mrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("mrst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("mrst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_seq", 32'(seq), 32'd0);
        chk("mrst_err", 32'(err_timeout), 32'd0);
        rx_q.delete();
        sent_q.delete();
        pend = 1'b0;
        prev_rd = 1'b0;
        hold = 1'b0;
        bus.fifo_valid = 1'b0;
        rd_frame_cnt = 0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        collect(FLEN, 100);
        bus.package_ready = 1'b0;
        check_frame("mrst", 16'h0000);
        rd_frame_cnt = 0;
        step();
        step();
        chk("mrst_seq_after", 32'(seq), 32'd1);

        // Sequence wrap from 0xFFFF
        force dut.seq_q = 16'hFFFF;
        #1;
        release dut.seq_q;
        chk("wrap_pre", 32'(seq), 32'hFFFF);
        bus.package_ready = 1'b1;
        collect(FLEN, 100);
        bus.package_ready = 1'b0;
        check_frame("wrap", 16'hFFFF);
        step();
        step();
        chk("wrap_seq", 32'(seq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
